// File: rtl/note_scheduler.sv
// Chart-driven arrow spawn scheduler: steps through a chart ROM once every
// FRAMES_PER_STEP frame pulses and issues per-lane spawn requests.
module note_scheduler #(
   parameter int LANES           = 4,
   parameter int CHART_AW        = 6,
   parameter int FRAMES_PER_STEP = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                frame_i,
   input  logic                start_i,
   input  logic                pause_i,
   output logic [CHART_AW-1:0] chart_addr_o,
   input  logic [LANES:0]      chart_data_i,
   output logic [LANES-1:0]    spawn_valid_o,
   input  logic [LANES-1:0]    spawn_ready_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [CHART_AW-1:0] step_o,
   output logic [7:0]          miss_cnt_o
);

   typedef enum logic [2:0] {
      IDLE, FETCH, LATCH, ISSUE, WAIT_STEP, DONE
   } state_e;

   localparam logic [CHART_AW-1:0] LastStep  = '1;
   localparam logic [7:0]          FrameLast = 8'(FRAMES_PER_STEP - 1);

   state_e              state_q;
   logic [CHART_AW-1:0] step_q;
   logic [7:0]          frame_q;
   logic [7:0]          miss_q;
   logic                due_q;
   logic [LANES-1:0]    pend_q;

   logic             busy;
   logic             pulse;
   logic             wrap;
   logic             due_now;
   logic [LANES-1:0] left;
   logic [8:0]       miss_sum;
   logic [7:0]       miss_sat;

   function automatic logic [8:0] popcnt(input logic [LANES-1:0] v);
      logic [8:0] n;
      n = '0;
      for (int i = 0; i < LANES; i++) begin
         n = n + 9'(v[i]);
      end
      return n;
   endfunction

   assign busy     = (state_q != IDLE) && (state_q != DONE);
   assign pulse    = busy && frame_i && !pause_i;
   assign wrap     = pulse && (frame_q == FrameLast);
   assign due_now  = wrap || due_q;
   // lanes still unaccepted this cycle; on overrun these are the misses
   assign left     = pend_q & ~spawn_ready_i;
   assign miss_sum = {1'b0, miss_q} + popcnt(left);
   assign miss_sat = miss_sum[8] ? 8'hFF : miss_sum[7:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         step_q  <= '0;
         frame_q <= '0;
         miss_q  <= '0;
         due_q   <= 1'b0;
         pend_q  <= '0;
      end else begin
         if (pulse) begin
            frame_q <= wrap ? 8'd0 : frame_q + 8'd1;
         end
         unique case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  state_q <= FETCH;
                  step_q  <= '0;
                  frame_q <= '0;
                  miss_q  <= '0;
                  due_q   <= 1'b0;
               end
            end
            FETCH: begin
               state_q <= LATCH;
               if (wrap) due_q <= 1'b1;
            end
            LATCH: begin
               if (wrap) due_q <= 1'b1;
               if (chart_data_i[LANES]) begin
                  state_q <= DONE;
               end else begin
                  pend_q  <= chart_data_i[LANES-1:0];
                  state_q <= ISSUE;
               end
            end
            ISSUE, WAIT_STEP: begin
               pend_q <= due_now ? '0 : left;
               if (due_now) begin
                  miss_q <= miss_sat;
                  due_q  <= 1'b0;
                  if (step_q == LastStep) begin
                     state_q <= DONE;
                  end else begin
                     step_q  <= step_q + 1'b1;
                     state_q <= FETCH;
                  end
               end else if (left == '0) begin
                  state_q <= WAIT_STEP;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign chart_addr_o  = step_q;
   assign spawn_valid_o = pend_q;
   assign busy_o        = busy;
   assign done_o        = (state_q == DONE);
   assign step_o        = step_q;
   assign miss_cnt_o    = miss_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed vectors, corner sequences and a
// random run against an abstract step/lane model.
module tb_note_scheduler;

   localparam int L     = 4;
   localparam int AW    = 2;
   localparam int FPS   = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          frame = 1'b0;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic [AW-1:0] addr;
   logic [L:0]    data = '0;
   logic [L-1:0]  valid;
   logic [L-1:0]  ready = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] step;
   logic [7:0]    miss;

   logic [L:0] rom [DEPTH];
   int errors = 0;
   int checks = 0;

   note_scheduler #(
      .LANES(L), .CHART_AW(AW), .FRAMES_PER_STEP(FPS)
   ) dut (
      .clk_i(clk), .rst_i(rst), .frame_i(frame),
      .start_i(start), .pause_i(pause),
      .chart_addr_o(addr), .chart_data_i(data),
      .spawn_valid_o(valid), .spawn_ready_i(ready),
      .busy_o(busy), .done_o(done),
      .step_o(step), .miss_cnt_o(miss)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) data <= rom[addr];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors < 30)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse1();
      frame = 1'b1;
      cyc();
      frame = 1'b0;
   endtask

   task automatic pulses(input int n);
      for (int k = 0; k < n; k++) begin
         pulse1();
         cyc();
         cyc();
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1; frame = 1'b0; start = 1'b0;
      pause = 1'b0; ready = '0;
      cyc();
      rst = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   // abstract model: one chart step at a time, pending lanes as a set
   int          m_step, m_miss, m_fc, m_age;
   bit          m_busy, m_done, m_held, m_iss;
   bit [L-1:0]  m_pend;

   task automatic model_reset();
      m_step = 0; m_miss = 0; m_fc = 0; m_age = 0;
      m_busy = 0; m_done = 0; m_held = 0; m_iss = 0;
      m_pend = '0;
   endtask

   task automatic model_step(input bit r, input bit s, input bit f,
                             input bit p, input bit [L-1:0] rd);
      bit wr;
      int n;
      if (r) begin
         model_reset();
         return;
      end
      wr = 0;
      if (m_busy && f && !p) begin
         m_fc++;
         if (m_fc == FPS) begin
            m_fc = 0;
            wr = 1;
         end
      end
      if (!m_busy) begin
         if (s) begin
            model_reset();
            m_busy = 1;
         end
      end else if (m_age == 0) begin
         m_age = 1;
         m_held |= wr;
      end else if (m_age == 1) begin
         m_held |= wr;
         if (rom[m_step][L]) begin
            m_busy = 0;
            m_done = 1;
         end else begin
            m_pend = rom[m_step][L-1:0];
            m_iss  = 1;
            m_age  = 2;
         end
      end else if (wr || m_held) begin
         n = m_miss + $countones(m_pend & ~rd);
         m_miss = (n > 255) ? 255 : n;
         m_pend = '0; m_iss = 0; m_held = 0;
         if (m_step == DEPTH - 1) begin
            m_busy = 0;
            m_done = 1;
         end else begin
            m_step++;
            m_age = 0;
         end
      end else if (m_iss) begin
         m_pend &= ~rd;
         if (m_pend == '0) m_iss = 0;
      end
   endtask

   typedef struct {
      logic [L-1:0] mask;
      logic [L-1:0] rdy;
      int           miss;
   } vec_t;

   vec_t tbl[6];

   initial begin
      bit pf;
      bit r, s, f;
      logic [L-1:0] rd;

      tbl[0] = '{4'b1111, 4'b0000, 4};
      tbl[1] = '{4'b1111, 4'b1111, 0};
      tbl[2] = '{4'b0000, 4'b0000, 0};
      tbl[3] = '{4'b1010, 4'b1000, 1};
      tbl[4] = '{4'b0110, 4'b0000, 2};
      tbl[5] = '{4'b0101, 4'b0100, 1};

      for (int i = 0; i < DEPTH; i++) rom[i] = '0;
      @(negedge clk);
      reset_dut();
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst valid", valid, 0);
      chk("rst step", step, 0);
      chk("rst miss", miss, 0);
      chk("rst addr", addr, 0);

      // single-step overrun vectors, ready held constant
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < DEPTH; j++) rom[j] = 5'b10000;
         rom[0] = {1'b0, tbl[i].mask};
         reset_dut();
         ready = tbl[i].rdy;
         go();
         cyc();
         cyc();
         chk("vec valid", valid, tbl[i].mask);
         pulses(7);
         chk("vec held", valid, tbl[i].mask & ~tbl[i].rdy);
         pulses(1);
         chk("vec done", done, 1);
         chk("vec step", step, 1);
         chk("vec miss", miss, tbl[i].miss);
         chk("vec drop", valid, 0);
      end

      // two-step chart with end marker, all lanes ready
      rom[0] = 5'b00001; rom[1] = 5'b00110;
      rom[2] = 5'b10000; rom[3] = 5'b10000;
      reset_dut();
      ready = '1;
      go();
      chk("c33 addr", addr, 0);
      cyc();
      cyc();
      chk("c33 v0", valid, 4'b0001);
      cyc();
      chk("c33 v0 off", valid, 0);
      pulses(7);
      chk("c33 early", step, 0);
      pulse1();
      chk("c33 spacing", step, 1);
      cyc();
      cyc();
      chk("c33 v1", valid, 4'b0110);
      cyc();
      chk("c33 v1 off", valid, 0);
      pulses(8);
      chk("c33 done", done, 1);
      chk("c33 step", step, 2);
      chk("c33 miss", miss, 0);

      // lane 0 accepted on the overrun cycle itself
      rom[0] = 5'b00111; rom[1] = 5'b10000;
      reset_dut();
      go();
      cyc();
      cyc();
      pulses(7);
      ready = 4'b0001;
      pulse1();
      ready = '0;
      chk("c35 miss", miss, 2);
      chk("c35 step", step, 1);
      chk("c35 valid", valid, 0);

      // pause during WAIT_STEP
      rom[0] = '0; rom[1] = '0; rom[2] = '0; rom[3] = 5'b10000;
      reset_dut();
      go();
      cyc();
      cyc();
      cyc();
      pause = 1'b1;
      pulses(20);
      chk("c36 paused", step, 0);
      chk("c36 busy", busy, 1);
      pause = 1'b0;
      pulses(7);
      chk("c36 count", step, 0);
      pulse1();
      chk("c36 resume", step, 1);

      // reset mid-ISSUE
      rom[0] = 5'b01010;
      reset_dut();
      go();
      cyc();
      cyc();
      chk("c37 valid", valid, 4'b1010);
      rst = 1'b1;
      cyc();
      chk("c37 valid0", valid, 0);
      chk("c37 busy", busy, 0);
      chk("c37 step", step, 0);
      chk("c37 done", done, 0);
      rst = 1'b0;
      cyc();
      chk("c37 quiet v", valid, 0);
      chk("c37 quiet b", busy, 0);
      chk("c37 quiet d", done, 0);

      // no end marker: runs off the last address into DONE
      for (int j = 0; j < DEPTH; j++) rom[j] = '0;
      reset_dut();
      go();
      pulses(8);
      chk("c38 s1", step, 1);
      go();
      chk("c38 ign step", step, 1);
      chk("c38 ign busy", busy, 1);
      pulses(8);
      chk("c38 s2", step, 2);
      pulses(7);
      pulse1();
      chk("c38 s3", step, 3);
      pulses(7);
      pulse1();
      chk("c38 done", done, 1);
      chk("c38 last", step, 3);
      chk("c38 idle", busy, 0);
      cyc();
      cyc();
      chk("c38 hold", done, 1);
      go();
      chk("c38 rst step", step, 0);
      chk("c38 rbusy", busy, 1);
      chk("c38 rdone", done, 0);

      // random run against the model
      reset_dut();
      model_reset();
      pf = 0;
      for (int c = 0; c < 6000; c++) begin
         chk("rnd valid", valid, m_pend);
         chk("rnd busy", busy, m_busy);
         chk("rnd done", done, m_done);
         chk("rnd step", step, m_step);
         chk("rnd miss", miss, m_miss);
         if (m_busy && m_age == 0) chk("rnd addr", addr, m_step);
         r = ($urandom_range(0, 799) == 0);
         s = ($urandom_range(0, 9) == 0);
         f = !pf && ($urandom_range(0, 2) == 0);
         pf = f;
         if ($urandom_range(0, 59) == 0) pause = ~pause;
         rd = L'($urandom & $urandom & $urandom);
         if (s && !m_busy) begin
            for (int j = 0; j < DEPTH; j++) begin
               rom[j] = {($urandom_range(0, 5) == 0), L'($urandom)};
            end
         end
         rst = r; start = s; frame = f; ready = rd;
         model_step(r, s, f, pause, rd);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 SHALL have parameter LANES, default 4, number of arrow lanes.
REQ-002 SHALL have parameter CHART_AW, default 6, chart address width (chart depth 2**CHART_AW).
REQ-003 SHALL have parameter FRAMES_PER_STEP, default 8, frame pulses per chart step, legal range 2..255.
REQ-004 SHALL have port clk_i  input  1  pixel clock, the only clock.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port frame_i  input  1  one-cycle pulse at start of vertical blanking.
REQ-007 SHALL have port start_i  input  1  start chart playback from address 0.
REQ-008 SHALL have port pause_i  input  1  level; while high, frame_i is ignored.
REQ-009 SHALL have port chart_addr_o  output  CHART_AW  chart ROM read address.
REQ-010 SHALL have port chart_data_i  input  LANES+1  ROM data, valid exactly 1 cycle after chart_addr_o; bit LANES = end marker, bits LANES-1:0 = lane mask.
REQ-011 SHALL have port spawn_valid_o  output  LANES  per-lane arrow spawn request.
REQ-012 SHALL have port spawn_ready_i  input  LANES  per-lane arrow engine accepts spawn.
REQ-013 SHALL have port busy_o  output  1  high in any state other than IDLE and DONE.
REQ-014 SHALL have port done_o  output  1  high in DONE.
REQ-015 SHALL have port step_o  output  CHART_AW  index of current chart step.
REQ-016 SHALL have port miss_cnt_o  output  8  count of spawns dropped by overrun, saturating at 255.

Function
REQ-017 SHALL implement states IDLE, FETCH, LATCH, ISSUE, WAIT_STEP, DONE.
REQ-018 IDLE: start_i=1 -> FETCH; step_o<=0, frame counter<=0, miss_cnt_o<=0.
REQ-019 FETCH: drive chart_addr_o=step_o for one cycle; -> LATCH.
REQ-020 LATCH: capture chart_data_i; end marker=1 -> DONE; else pending<=lane mask, -> ISSUE.
REQ-021 ISSUE: spawn_valid_o=pending; lane bit cleared in the cycle where valid&ready; when pending becomes 0 -> WAIT_STEP; zero mask passes through ISSUE in one cycle.
REQ-022 spawn_valid_o bit, once asserted, SHALL stay high until accepted or dropped (REQ-025); spawn_valid_o=0 outside ISSUE.
REQ-023 Frame counter: counts frame_i pulses (pause_i=0) in FETCH, LATCH, ISSUE, WAIT_STEP; on the pulse reaching FRAMES_PER_STEP-1 it wraps to 0 and raises step_due.
REQ-024 WAIT_STEP with step_due: clear step_due, step_o<=step_o+1, -> FETCH; if step_o is already 2**CHART_AW-1 -> DONE instead (no wrap).
REQ-025 step_due raised while in ISSUE (overrun): drop all pending lanes that cycle, miss_cnt_o += popcount(pending) (saturating), then advance per REQ-024.
REQ-026 Acceptance and overrun in same cycle: accepted lanes are not counted as missed.
REQ-027 step_due raised in FETCH or LATCH SHALL be held and serviced on reaching WAIT_STEP/ISSUE; a second step_due while one is held is discarded.
REQ-028 DONE: start_i=1 -> behaves as IDLE start (REQ-018); otherwise hold, outputs stable.
REQ-029 start_i while busy_o=1 SHALL be ignored.
REQ-030 Step spacing: FETCH of step n+1 begins exactly 1 cycle after the frame pulse that completes FRAMES_PER_STEP pulses from step n's start.

Reset
REQ-031 rst_i=1 on a clock edge SHALL force IDLE, step_o=0, miss_cnt_o=0, frame counter=0, step_due=0, pending=0, chart_addr_o=0, spawn_valid_o=0, busy_o=0, done_o=0, regardless of state, including mid-ISSUE.
REQ-032 No output SHALL assert in the cycle after rst_i deasserts unless start_i is sampled.

Verification
REQ-033 Chart {0001,0110,end}, ready=all 1, FRAMES_PER_STEP=8 -> spawn_valid_o=0001 once, 0110 after 8th frame pulse, done_o=1 at step_o=2, miss_cnt_o=0.
REQ-034 Mask 1111, spawn_ready_i=0 for all lanes across 8 frames -> valid held 8 frames, then dropped, miss_cnt_o=4, step_o advances to 1.
REQ-035 Lane 0 ready same cycle as step_due, others not ready, mask 0111 -> miss_cnt_o=2.
REQ-036 pause_i=1 for 20 frame pulses during WAIT_STEP -> step_o unchanged; resumes counting after release.
REQ-037 rst_i pulsed mid-ISSUE with valid=1010 -> next cycle spawn_valid_o=0, busy_o=0, step_o=0.
REQ-038 Chart with no end marker, CHART_AW=2 -> steps 0..3 fetched, then done_o=1; start_i while busy ignored, start_i in DONE restarts at step 0.
